// File: rtl/id_decode_queue.sv
// Instruction decode queue: a DEPTH-entry FIFO that decodes each instruction on entry
// and tags the instruction after an accepted branch as its delay slot.
module id_decode_queue #(
    parameter int DEPTH = 4,
    parameter bit DS_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic                     out_br,
    output logic                     out_mem,
    output logic                     out_sys,
    output logic                     out_brk,
    output logic                     out_eret,
    output logic                     out_ri,
    output logic                     out_bd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Class flags packed as {br, mem, sys, brk, eret, ri}.
    function automatic logic [5:0] f_decode(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] func;
        logic [4:0] rt;
        logic       regimm_ok;
        logic       br;
        logic       mem;
        logic       sys;
        logic       brk;
        logic       eret;
        logic       ri;
        op        = inst[31:26];
        rt        = inst[20:16];
        func      = inst[5:0];
        regimm_ok = (rt == 5'h00) || (rt == 5'h01) || (rt == 5'h10) || (rt == 5'h11);
        br        = ((op >= 6'h02) && (op <= 6'h07)) ||
                    ((op == 6'h01) && regimm_ok) ||
                    ((op == 6'h00) && ((func == 6'h08) || (func == 6'h09)));
        case (op)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: mem = 1'b1;
            default:                                  mem = 1'b0;
        endcase
        sys  = (op == 6'h00) && (func == 6'h0C);
        brk  = (op == 6'h00) && (func == 6'h0D);
        eret = (inst == 32'h4200_0018);
        ri   = ((op > 6'h10) && !mem) || ((op == 6'h01) && !regimm_ok);
        return {br, mem, sys, brk, eret, ri};
    endfunction

    logic [31:0]   r_inst_mem [DEPTH];
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [6:0]    r_flag_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ds_pend;

    logic          w_push;
    logic          w_pop;
    logic [5:0]    w_dec;
    logic          w_bd_in;
    logic [6:0]    w_head_flags;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign w_dec     = f_decode(in_inst);
    assign w_bd_in   = DS_EN && r_ds_pend;

    // Payload storage carries no reset; the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= in_inst;
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_flag_mem[r_wr_ptr] <= {w_dec, w_bd_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ds_pend <= 1'b0;
        end else if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ds_pend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                // A branch (even one sitting in a delay slot) re-arms the flag.
                r_ds_pend <= w_dec[5];
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_flags = out_valid ? r_flag_mem[r_rd_ptr] : 7'd0;
    assign out_inst     = out_valid ? r_inst_mem[r_rd_ptr] : 32'd0;
    assign out_pc       = out_valid ? r_pc_mem[r_rd_ptr]   : 32'd0;
    assign out_br       = w_head_flags[6];
    assign out_mem      = w_head_flags[5];
    assign out_sys      = w_head_flags[4];
    assign out_brk      = w_head_flags[3];
    assign out_eret     = w_head_flags[2];
    assign out_ri       = w_head_flags[1];
    assign out_bd       = w_head_flags[0];
    assign count        = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench for id_decode_queue: decode classes, delay-slot tagging, FIFO order,
// full/stream behaviour, flush and asynchronous reset.
module tb_id_decode_queue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_br;
    logic        out_mem;
    logic        out_sys;
    logic        out_brk;
    logic        out_eret;
    logic        out_ri;
    logic        out_bd;
    logic [2:0]  count;

    int n_checks;
    int n_errors;

    id_decode_queue #(.DEPTH(4), .DS_EN(1'b1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_br    (out_br),
        .out_mem   (out_mem),
        .out_sys   (out_sys),
        .out_brk   (out_brk),
        .out_eret  (out_eret),
        .out_ri    (out_ri),
        .out_bd    (out_bd),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {br, mem, sys, brk, eret, ri, bd}
    logic [6:0] flags;
    assign flags = {out_br, out_mem, out_sys, out_brk, out_eret, out_ri, out_bd};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] batch_inst [4];
    logic [6:0]  batch_flag [4];
    logic [31:0] q [$];
    int          nxt;
    int          cyc;
    logic        exp_push;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_inst",      out_inst,       32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // J followed by its delay slot; no bypass in the accept cycle.
        in_valid = 1'b1; in_inst = 32'h0800_0010; in_pc = 32'hBFC0_0000;
        #1;
        chk("nobypass_valid", 32'(out_valid), 32'd0);
        step();
        chk("j_valid", 32'(out_valid), 32'd1);
        chk("j_flags", 32'(flags),     32'b1000000);
        chk("j_pc",    out_pc,         32'hBFC0_0000);
        in_inst = 32'h2402_0001; in_pc = 32'hBFC0_0004; out_ready = 1'b1;
        step();
        chk("ds_flags", 32'(flags),     32'b0000001);
        chk("ds_pc",    out_pc,         32'hBFC0_0004);
        chk("ds_count", 32'(count),     32'd1);
        in_valid = 1'b0;
        step();
        chk("ds_drain", 32'(count), 32'd0);

        // Special classes, then memory/regimm/delay-slot chain.
        batch_inst[0] = 32'h0000_000C; batch_flag[0] = 7'b0010000;
        batch_inst[1] = 32'h0000_000D; batch_flag[1] = 7'b0001000;
        batch_inst[2] = 32'h4200_0018; batch_flag[2] = 7'b0000100;
        batch_inst[3] = 32'hFC00_0000; batch_flag[3] = 7'b0000010;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                batch_inst[0] = 32'h8C82_0000; batch_flag[0] = 7'b0100000;
                batch_inst[1] = 32'h0402_0000; batch_flag[1] = 7'b0000010;
                batch_inst[2] = 32'h0411_0000; batch_flag[2] = 7'b1000000;
                batch_inst[3] = 32'h03E0_0008; batch_flag[3] = 7'b1000001;
            end
            out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1; in_inst = batch_inst[k]; in_pc = 32'h100 + 32'(4 * k);
                step();
            end
            in_valid = 1'b0; out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cls%0d_inst%0d", r, k), out_inst, batch_inst[k]);
                chk($sformatf("cls%0d_flag%0d", r, k), 32'(flags), 32'(batch_flag[k]));
                step();
            end
        end
        // Pending flag from JR survived the idle pop cycles.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0000_0000;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("persist_bd", 32'(flags), 32'b0000001);
        out_ready = 1'b1;
        step();
        chk("persist_drain", 32'(count), 32'd0);

        // Fill with consumer stalled; fifth offer is held.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h2400_0000 + 32'(k); in_pc = 32'h1000 + 32'(4 * k);
            step();
            chk($sformatf("fill_count%0d", k), 32'(count), 32'(k + 1));
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_inst = 32'h2400_0004;
        step();
        chk("held_count", 32'(count), 32'd4);
        chk("held_head",  out_inst,   32'h2400_0000);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("order%0d", k), out_inst, 32'h2400_0000 + 32'(k));
            step();
        end
        chk("order_count", 32'(count), 32'd0);

        // Streaming from full: in_ready ignores out_ready, so the queue settles at 3.
        q.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h2400_0100 + 32'(k);
            step();
            q.push_back(32'h2400_0100 + 32'(k));
        end
        out_ready = 1'b1;
        nxt = 4;
        cyc = 0;
        while (nxt < 14 && cyc < 40) begin
            in_inst  = 32'h2400_0100 + 32'(nxt);
            exp_push = (q.size() < 4);
            #1;
            chk($sformatf("strm_ready%0d", cyc), 32'(in_ready), 32'(exp_push));
            chk($sformatf("strm_head%0d", cyc),  out_inst,      q[0]);
            chk($sformatf("strm_count%0d", cyc), 32'(count),    32'(q.size()));
            step();
            void'(q.pop_front());
            if (exp_push) begin
                q.push_back(32'h2400_0100 + 32'(nxt));
                nxt++;
            end
            cyc++;
        end
        chk("strm_bound", 32'(nxt), 32'd14);
        in_valid = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 10) begin
            chk($sformatf("strm_drain%0d", cyc), out_inst, q[0]);
            step();
            void'(q.pop_front());
            cyc++;
        end
        chk("strm_empty", 32'(count), 32'd0);

        // Flush alongside the delay-slot push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h1000_0002;
        step();
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        in_inst = 32'h2402_0005; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", 32'(count),     32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_inst = 32'h2402_0006;
        step();
        in_valid = 1'b0;
        chk("fl_next_inst", out_inst,   32'h2402_0006);
        chk("fl_next_bd",   32'(flags), 32'b0000000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a clock high phase.
        in_valid = 1'b1; in_inst = 32'h2402_0007;
        step();
        in_inst = 32'h1000_0003;
        step();
        in_valid = 1'b0;
        chk("ar_pre_count", 32'(count), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_count", 32'(count),     32'd0);
        chk("ar_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        resetn = 1'b1;
        in_valid = 1'b1; in_inst = 32'h2402_0008;
        step();
        in_valid = 1'b0;
        chk("ar_next_inst", out_inst,   32'h2402_0008);
        chk("ar_next_bd",   32'(flags), 32'b0000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
